// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, fixed baud divider and polled status.
// Define UART_TX_IRQ_EN to build the TX-done interrupt (irq output, CTRL[2] irq_en).
module uart_tx_mmio #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        ser_out,
    output logic        tx_busy,
    output logic        irq
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(BAUD_DIV);

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_next;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full, fifo_empty;
    logic              tx_en, overflow, irq_en;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]        bit_idx, bit_next;
    logic [7:0]        shift, shift_next;
    logic              ser_next, baud_end, can_pop, pop;
    logic              wr_txdata, wr_ctrl, push, ovf_set, ovf_clr;
    logic [31:0]       rdata_next;
    logic              unused_wdata;

    assign unused_wdata = ^bus_wdata[31:8];

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign wr_txdata  = bus_we && (bus_addr == ADDR_TXDATA);
    assign wr_ctrl    = bus_we && (bus_addr == ADDR_CTRL);
    // A full FIFO still takes the byte when the FSM frees a slot in the same cycle.
    assign push       = wr_txdata && (!fifo_full || pop);
    assign ovf_set    = wr_txdata && fifo_full && !pop;
    assign ovf_clr    = wr_ctrl && bus_wdata[1];
    assign baud_end   = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
    assign can_pop    = tx_en && !fifo_empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) tx_en <= bus_wdata[0];
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        ser_next   = ser_out;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    state_next = START;
                    shift_next = fifo_mem[rd_ptr];
                    ser_next   = 1'b0;
                    baud_next  = '0;
                end
            end
            START: begin
                baud_next = baud_cnt + BAUD_W'(1);
                if (baud_end) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    ser_next   = shift[0];
                end
            end
            DATA: begin
                baud_next = baud_cnt + BAUD_W'(1);
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        ser_next   = 1'b1;
                    end else begin
                        shift_next = shift >> 1;
                        ser_next   = shift[1];
                        bit_next   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                baud_next = baud_cnt + BAUD_W'(1);
                if (baud_end) begin
                    baud_next = '0;
                    if (can_pop) begin
                        pop        = 1'b1;
                        state_next = START;
                        shift_next = fifo_mem[rd_ptr];
                        ser_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            ser_out  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            ser_out  <= ser_next;
            tx_busy  <= (state_next != IDLE);
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_q, irq_set, irq_clr;

    assign irq_set = (state == STOP) && baud_end && !can_pop && fifo_empty && irq_en;
    // Firmware acknowledgement wins over a completion landing in the same cycle.
    assign irq_clr = wr_txdata || (wr_ctrl && !bus_wdata[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= bus_wdata[2];
            if (irq_clr)      irq_q <= 1'b0;
            else if (irq_set) irq_q <= 1'b1;
        end
    end

    assign irq = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rdata_next = '0;
        case (bus_addr)
            ADDR_STATUS: begin
                rdata_next[0]          = fifo_full;
                rdata_next[1]          = fifo_empty;
                rdata_next[2]          = tx_busy;
                rdata_next[3]          = overflow;
                rdata_next[8 +: CNT_W] = count;
            end
            ADDR_CTRL: begin
                rdata_next[0] = tx_en;
                rdata_next[2] = irq_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       bus_rdata <= '0;
        else if (bus_re) bus_rdata <= rdata_next;
    end

endmodule
